// File: rtl/aes_round_ctrl.sv
// Round sequencer for an iterative AES-128/192/256 encryption core: it walks the
// key schedule round by round and issues one state-register load strobe per round.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic       key_ready,
    output logic       key_req,
    output logic [3:0] round_num,
    output logic       ld_init,
    output logic       ld_round,
    output logic       mix_bypass,
    output logic       busy,
    output logic       done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] KEYWAIT = 2'd1;
    localparam logic [1:0] LOAD    = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    logic [1:0] state;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            round_num <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= KEYWAIT;
                        round_num <= '0;
                    end
                end
                KEYWAIT: begin
                    if (abort) begin
                        state     <= IDLE;
                        round_num <= '0;
                    end else if (key_ready) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state     <= IDLE;
                        round_num <= '0;
                    end else if (round_num == LAST_ROUND) begin
                        state <= DONE;
                    end else begin
                        state     <= KEYWAIT;
                        round_num <= round_num + 4'd1;
                    end
                end
                default: state <= IDLE;  // DONE lasts exactly one cycle
            endcase
        end
    end

    // Every output is a pure decode of registered state, so no input reaches an output
    // within the same cycle.
    assign key_req    = (state == KEYWAIT);
    assign ld_init    = (state == LOAD) && (round_num == 4'd0);
    assign ld_round   = (state == LOAD) && (round_num != 4'd0);
    assign mix_bypass = (state == LOAD) && (round_num == LAST_ROUND);
    assign busy       = (state == KEYWAIT) || (state == LOAD);
    assign done       = (state == DONE);

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: an NR=10 and an NR=14 instance share stimulus;
// each scenario records outputs per cycle, counted from the edge that samples start.
module tb_aes_round_ctrl;

    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, key_ready;
    logic       key_req, ld_init, ld_round, mix_bypass, busy, done;
    logic [3:0] round_num;
    logic       key_req14, ld_init14, ld_round14, mix_bypass14, busy14, done14;
    logic [3:0] round_num14;

    int errors = 0;
    int checks = 0;

    logic       r_busy [MAXC], r_kreq [MAXC], r_init [MAXC], r_round [MAXC];
    logic       r_mix [MAXC], r_done [MAXC], r_done14 [MAXC], r_mix14 [MAXC];
    logic [3:0] r_rnd [MAXC], r_rnd14 [MAXC];

    typedef struct {
        int cyc;
        bit busy, kreq, init, ldr, mix, dn;
        int rnd;
    } vec_t;

    always #5 clk = ~clk;

    aes_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_ready(key_ready),
        .key_req(key_req), .round_num(round_num), .ld_init(ld_init), .ld_round(ld_round),
        .mix_bypass(mix_bypass), .busy(busy), .done(done)
    );

    aes_round_ctrl #(.NR(14)) dut14 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_ready(key_ready),
        .key_req(key_req14), .round_num(round_num14), .ld_init(ld_init14),
        .ld_round(ld_round14), .mix_bypass(mix_bypass14), .busy(busy14), .done(done14)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse start into edge 0, then for cycles 1..n sample at the falling edge and
    // drive the inputs that the rising edge closing cycle c will see.
    task automatic run(input int n, input int st_lo, input int st_hi, input int kr_lo,
                       input int kr_hi, input int ab_at, input int rs_lo, input int rs_hi);
        @(negedge clk);
        start = 1'b1; key_ready = 1'b1; abort = 1'b0; rst_n = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            r_busy[c] = busy;   r_kreq[c] = key_req; r_init[c] = ld_init;
            r_round[c] = ld_round; r_mix[c] = mix_bypass; r_done[c] = done;
            r_rnd[c] = round_num; r_done14[c] = done14; r_mix14[c] = mix_bypass14;
            r_rnd14[c] = round_num14;
            start     = (c >= st_lo) && (c <= st_hi);
            key_ready = !((c >= kr_lo) && (c <= kr_hi));
            abort     = (c == ab_at);
            rst_n     = !((c >= rs_lo) && (c <= rs_hi));
        end
        start = 1'b0; key_ready = 1'b1; abort = 1'b0; rst_n = 1'b1;
    endtask

    function automatic int count_done(input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) if (r_done[c]) k++;
        return k;
    endfunction

    vec_t basic [10];

    initial begin
        int k;
        basic[0] = '{1,  1, 1, 0, 0, 0, 0, 0};
        basic[1] = '{2,  1, 0, 1, 0, 0, 0, 0};
        basic[2] = '{3,  1, 1, 0, 0, 0, 0, 1};
        basic[3] = '{4,  1, 0, 0, 1, 0, 0, 1};
        basic[4] = '{20, 1, 0, 0, 1, 0, 0, 9};
        basic[5] = '{21, 1, 1, 0, 0, 0, 0, 10};
        basic[6] = '{22, 1, 0, 0, 1, 1, 0, 10};
        basic[7] = '{23, 0, 0, 0, 0, 0, 1, 10};
        basic[8] = '{24, 0, 0, 0, 0, 0, 0, 10};
        basic[9] = '{12, 1, 0, 0, 1, 0, 0, 5};

        // Reset with start and key_ready active: nothing may be accepted.
        rst_n = 1'b0; start = 1'b1; abort = 1'b0; key_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset key_req", key_req, 0);
        check("reset strobes", {ld_init, ld_round, mix_bypass, done}, 0);
        check("reset round_num", round_num, 0);
        start = 1'b0; rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle after reset", busy, 0);

        // Basic encryption, both NR values in parallel.
        run(34, 0, 0, 0, 0, 0, 0, 0);
        foreach (basic[i]) begin
            int c;
            c = basic[i].cyc;
            check($sformatf("basic c%0d busy", c), r_busy[c], basic[i].busy);
            check($sformatf("basic c%0d key_req", c), r_kreq[c], basic[i].kreq);
            check($sformatf("basic c%0d ld_init", c), r_init[c], basic[i].init);
            check($sformatf("basic c%0d ld_round", c), r_round[c], basic[i].ldr);
            check($sformatf("basic c%0d mix_bypass", c), r_mix[c], basic[i].mix);
            check($sformatf("basic c%0d done", c), r_done[c], basic[i].dn);
            check($sformatf("basic c%0d round_num", c), r_rnd[c], basic[i].rnd);
        end
        for (int c = 1; c <= 24; c++) begin
            check($sformatf("basic ld_round c%0d", c), r_round[c],
                  ((c % 2 == 0) && c >= 4 && c <= 22) ? 1 : 0);
            check($sformatf("basic busy c%0d", c), r_busy[c], (c <= 22) ? 1 : 0);
        end
        k = 0;
        for (int c = 1; c <= 34; c++) if (r_mix[c]) k++;
        check("basic mix_bypass count", k, 1);
        check("basic done count", count_done(1, 34), 1);
        for (int c = 1; c <= 34; c++) begin
            check($sformatf("nr14 done c%0d", c), r_done14[c], (c == 31) ? 1 : 0);
            check($sformatf("nr14 mix c%0d", c), r_mix14[c], (c == 30) ? 1 : 0);
        end
        check("nr14 round at last load", r_rnd14[30], 14);

        // Key stall: five cycles without key_ready in KEYWAIT of round 3.
        run(40, 0, 0, 7, 11, 0, 0, 0);
        for (int c = 7; c <= 12; c++) begin
            check($sformatf("stall key_req c%0d", c), r_kreq[c], 1);
            check($sformatf("stall round c%0d", c), r_rnd[c], 3);
        end
        check("stall ld_round c13", r_round[13], 1);
        check("stall done c28", r_done[28], 1);
        check("stall done count", count_done(1, 40), 1);

        // Abort during LOAD of round 5, then a fresh start at cycle 20.
        run(46, 20, 20, 0, 0, 12, 0, 0);
        check("abort load c12 round", r_rnd[12], 5);
        check("abort c13 busy", r_busy[13], 0);
        check("abort c13 round", r_rnd[13], 0);
        check("abort c13 strobes", {r_init[13], r_round[13], r_kreq[13]}, 0);
        check("abort no done", count_done(1, 20), 0);
        check("restart c22 ld_init", r_init[22], 1);
        check("restart done c43", r_done[43], 1);
        check("restart done count", count_done(21, 46), 1);

        // Abort in KEYWAIT with key_ready high: no load follows.
        run(30, 0, 0, 0, 0, 5, 0, 0);
        check("abort kw c5 key_req", r_kreq[5], 1);
        check("abort kw c6 ld_round", r_round[6], 0);
        check("abort kw c6 busy", r_busy[6], 0);
        check("abort kw no done", count_done(1, 30), 0);

        // Reset in KEYWAIT of round 7 with start held; start accepted once released.
        run(50, 15, 17, 0, 0, 0, 15, 16);
        check("rst c15 key_req", r_kreq[15], 1);
        check("rst c15 round", r_rnd[15], 7);
        check("rst c16 outputs", {r_busy[16], r_kreq[16], r_init[16], r_round[16],
                                  r_mix[16], r_done[16]}, 0);
        check("rst c16 round", r_rnd[16], 0);
        check("rst c17 busy", r_busy[17], 0);
        check("rst c18 busy", r_busy[18], 1);
        check("rst done c40", r_done[40], 1);
        check("rst done count", count_done(1, 50), 1);

        // Start held through cycles 1..30: one done at 23, restart from edge 24.
        run(50, 1, 30, 0, 0, 0, 0, 0);
        check("hold done c23", r_done[23], 1);
        check("hold done count 1..46", count_done(1, 46), 1);
        check("hold c24 busy", r_busy[24], 0);
        check("hold c25 busy", r_busy[25], 1);
        check("hold c25 round", r_rnd[25], 0);
        check("hold second done c47", r_done[47], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
